conversion_sequencer: RTL and testbench
=======================================

CONVERSION_SEQUENCER -- requirements
Module: conversion_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: minimum auto-zero duration in clk_i cycles (>=1).
REQ-002 Parameter INT_CYCLES, default 1000: fixed integrate-phase duration in clk_i cycles (>=1).
REQ-003 Parameter MAX_DEINT, default 4095: de-integrate cycle limit, <= 4095 (fits 12 bits).
REQ-004 Port: clk_i  input  1  system clock; the single clock for the whole block.
REQ-005 Port: rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 Port: start_i  input  1  one-cycle conversion request.
REQ-007 Port: abort_i  input  1  abort the current conversion.
REQ-008 Port: comp_i  input  1  comparator, already synchronized and filtered.
REQ-009 Port: analog_ready_i  input  1  AFE settled flag, already synchronized.
REQ-010 Port: result_ack_i  input  1  consumer acknowledge of the result.
REQ-011 Port: afe_sel_o  output  2  AFE phase: 00 auto-zero/idle, 01 integrate input, 10 de-integrate reference, 11 never driven.
REQ-012 Port: ref_sign_o  output  1  reference polarity for de-integrate.
REQ-013 Port: afe_reset_o  output  1  integrator reset/auto-zero switch.
REQ-014 Port: busy_o  output  1  high in any state other than IDLE.
REQ-015 Port: result_valid_o  output  1  result available, held until acknowledged.
REQ-016 Port: result_o  output  12  de-integrate count.
REQ-017 Port: result_sign_o  output  1  input polarity captured at the end of integrate.
REQ-018 Port: range_error_o  output  1  de-integrate limit hit without a comparator crossing.
REQ-019 Port: state_o  output  3  current state encoding, for debug status.

Function
REQ-020 States and encodings: IDLE=0, AUTOZERO=1, INTEGRATE=2, DEINT=3, DONE=4; the FSM shall never reach any other encoding.
REQ-021 IDLE: afe_sel_o=00, afe_reset_o=1. start_i=1 moves to AUTOZERO on the next cycle. start_i is ignored in every other state.
REQ-022 AUTOZERO: afe_sel_o=00, afe_reset_o=1; phase counter increments.
REQ-023 AUTOZERO exit: move to INTEGRATE once at least SETTLE_CYCLES cycles have been spent in AUTOZERO and analog_ready_i=1. With analog_ready_i=0 the block waits indefinitely.
REQ-024 INTEGRATE: afe_sel_o=01, afe_reset_o=0; lasts exactly INT_CYCLES cycles.
REQ-025 Last INTEGRATE cycle: capture comp_i into result_sign_o and ref_sign_o; both stay stable until the next INTEGRATE completes.
REQ-026 DEINT: afe_sel_o=10, afe_reset_o=0. Counter starts at 0 on the first DEINT cycle and increments each cycle.
REQ-027 Crossing: on the first DEINT cycle where comp_i != captured sign, load result_o = counter value, range_error_o=0, move to DONE. A crossing on the 1st DEINT cycle gives result 0.
REQ-028 Limit: if the counter reaches MAX_DEINT with no crossing, load result_o=MAX_DEINT, range_error_o=1, move to DONE. A crossing in the same cycle takes priority (range_error_o=0).
REQ-029 DONE: afe_sel_o=00, afe_reset_o=1, result_valid_o=1.
REQ-030 result_ack_i=1 while in DONE: return to IDLE and clear result_valid_o on the next cycle. result_ack_i outside DONE is ignored.
REQ-031 start_i and result_ack_i together in DONE: take the ack, ignore the start.
REQ-032 abort_i=1 in any state has highest priority: go to IDLE next cycle, clear result_valid_o, drive IDLE outputs. result_o, result_sign_o and range_error_o keep their last values.
REQ-033 result_o and range_error_o change only on entry to DONE. The counter never wraps and saturates at MAX_DEINT.
REQ-034 All outputs are registered, or decoded from the registered state only. No combinational path from any input to any output.

Reset
REQ-035 On rst_n_i=0, asynchronously and regardless of state: state=IDLE; afe_sel_o=00, afe_reset_o=1, ref_sign_o=0, busy_o=0, result_valid_o=0, result_o=0, result_sign_o=0, range_error_o=0, state_o=0, counter=0.
REQ-036 Reset asserted mid-conversion discards that conversion. After release, the block accepts start_i from the first active clk_i edge.

Structure
REQ-037 Shared package voltmeter_pkg holds the state encodings, the afe_sel encodings (AFE_AZ=00, AFE_INT=01, AFE_DEINT=10) and the 12-bit result width constant.
REQ-038 A single 12-bit clearable, saturating up-counter sub-module, phase_counter, is shared by AUTOZERO, INTEGRATE and DEINT. It is cleared on every state transition.

Verification (SETTLE_CYCLES=4, INT_CYCLES=8, MAX_DEINT=20)
REQ-039 Nominal: analog_ready_i=1, comp_i=1 through integrate, start pulse, comp_i drops on the 6th DEINT cycle -> AUTOZERO 4 cycles, INTEGRATE 8 cycles, result_o=5, result_sign_o=1, ref_sign_o=1, range_error_o=0, result_valid_o=1 until ack.
REQ-040 Overrange: comp_i held constant -> result_o=20, range_error_o=1, DONE after 21 DEINT cycles at most.
REQ-041 Ready stall: analog_ready_i=0 until the 10th AUTOZERO cycle -> INTEGRATE begins the cycle after analog_ready_i rises; afe_reset_o=1 throughout AUTOZERO.
REQ-042 Abort in the 3rd INTEGRATE cycle -> IDLE next cycle, afe_sel_o=00, busy_o=0, result_o unchanged from the previous conversion.
REQ-043 start_i and result_ack_i together in DONE -> IDLE, result_valid_o=0, no new conversion. Later start_i pulses during busy are ignored.
REQ-044 rst_n_i asserted during DEINT -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/voltmeter_pkg.sv
// Shared definitions for the dual-slope conversion sequencer: state encodings,
// AFE phase select codes and the result width.
package voltmeter_pkg;

    localparam int unsigned RESULT_W = 12;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StAutozero  = 3'd1,
        StIntegrate = 3'd2,
        StDeint     = 3'd3,
        StDone      = 3'd4
    } state_e;

    localparam logic [1:0] AFE_AZ    = 2'b00;
    localparam logic [1:0] AFE_INT   = 2'b01;
    localparam logic [1:0] AFE_DEINT = 2'b10;

endpackage

// File: rtl/conversion_sequencer_if.sv
// Control/status bundle between the conversion sequencer and its AFE/consumer.
interface conversion_sequencer_if;
    import voltmeter_pkg::*;

    logic                start_i;
    logic                abort_i;
    logic                comp_i;
    logic                analog_ready_i;
    logic                result_ack_i;
    logic [1:0]          afe_sel_o;
    logic                ref_sign_o;
    logic                afe_reset_o;
    logic                busy_o;
    logic                result_valid_o;
    logic [RESULT_W-1:0] result_o;
    logic                result_sign_o;
    logic                range_error_o;
    logic [2:0]          state_o;

    modport slave (
        input  start_i, abort_i, comp_i, analog_ready_i, result_ack_i,
        output afe_sel_o, ref_sign_o, afe_reset_o, busy_o, result_valid_o,
        output result_o, result_sign_o, range_error_o, state_o
    );

    modport master (
        output start_i, abort_i, comp_i, analog_ready_i, result_ack_i,
        input  afe_sel_o, ref_sign_o, afe_reset_o, busy_o, result_valid_o,
        input  result_o, result_sign_o, range_error_o, state_o
    );

endinterface

// File: rtl/phase_counter.sv
// Clearable up-counter that saturates at all-ones instead of wrapping.
module phase_counter
    import voltmeter_pkg::*;
#(
    parameter int unsigned Width = RESULT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/conversion_sequencer.sv
// Dual-slope ADC sequencer: auto-zero, fixed integrate, timed de-integrate against the
// reference until the comparator crosses or the count limit is hit.
module conversion_sequencer
    import voltmeter_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned INT_CYCLES    = 1000,
    parameter int unsigned MAX_DEINT     = 4095
) (
    input logic                   clk_i,
    input logic                   rst_n_i,
    conversion_sequencer_if.slave bus
);

    localparam logic [RESULT_W-1:0] SettleLast = RESULT_W'(SETTLE_CYCLES - 1);
    localparam logic [RESULT_W-1:0] IntLast    = RESULT_W'(INT_CYCLES - 1);
    localparam logic [RESULT_W-1:0] DeintMax   = RESULT_W'(MAX_DEINT);

    state_e              state_q, state_d;
    logic [RESULT_W-1:0] cnt;
    logic                cnt_clr, cnt_en, crossed;
    logic                sign_q;
    logic [RESULT_W-1:0] result_q;
    logic                range_err_q;

    assign crossed = (bus.comp_i != sign_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (bus.start_i) state_d = StAutozero;
            StAutozero:  if ((cnt >= SettleLast) && bus.analog_ready_i) state_d = StIntegrate;
            StIntegrate: if (cnt == IntLast) state_d = StDeint;
            StDeint:     if (crossed || (cnt >= DeintMax)) state_d = StDone;
            StDone:      if (bus.result_ack_i) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
        if (bus.abort_i) state_d = StIdle;
    end

    // Every transition restarts the shared phase count at zero.
    assign cnt_clr = (state_d != state_q);
    assign cnt_en  = (state_q != StIdle) && (state_q != StDone);

    phase_counter #(
        .Width (RESULT_W)
    ) u_phase_counter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            sign_q      <= 1'b0;
            result_q    <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIntegrate) && (state_d == StDeint)) begin
                sign_q <= bus.comp_i;
            end
            // A crossing on the limit cycle wins over the range error.
            if ((state_q == StDeint) && (state_d == StDone)) begin
                result_q    <= crossed ? cnt : DeintMax;
                range_err_q <= !crossed;
            end
        end
    end

    always_comb begin
        bus.afe_sel_o   = AFE_AZ;
        bus.afe_reset_o = 1'b1;
        unique case (state_q)
            StIntegrate: begin
                bus.afe_sel_o   = AFE_INT;
                bus.afe_reset_o = 1'b0;
            end
            StDeint: begin
                bus.afe_sel_o   = AFE_DEINT;
                bus.afe_reset_o = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.busy_o         = (state_q != StIdle);
    assign bus.result_valid_o = (state_q == StDone);
    assign bus.state_o        = state_q;
    assign bus.ref_sign_o     = sign_q;
    assign bus.result_sign_o  = sign_q;
    assign bus.result_o       = result_q;
    assign bus.range_error_o  = range_err_q;

endmodule

// File: tb/tb_conversion_sequencer.sv
// Directed bench for conversion_sequencer with a queue of expected conversion results.
module tb_conversion_sequencer;
    import voltmeter_pkg::*;

    localparam int unsigned SettleCycles = 4;
    localparam int unsigned IntCycles    = 8;
    localparam int unsigned MaxDeint     = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conversion_sequencer_if bus ();

    conversion_sequencer #(
        .SETTLE_CYCLES (SettleCycles),
        .INT_CYCLES    (IntCycles),
        .MAX_DEINT     (MaxDeint)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [11:0] result;
        logic        sign;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        int k = 0;
        while (bus.state_o !== st && k < 100) begin
            step();
            k++;
        end
        check(tag, 32'(bus.state_o), 32'(st));
    endtask

    // cross_at: DEINT cycle (1-based) on which comp flips, 0 = never.
    // ready_rise: AUTOZERO cycle on which analog_ready rises, 0 = high from the start.
    task automatic run_conv(input logic comp_int, input int cross_at, input int ready_rise,
                            input bit poke_start);
        exp_t e;
        int   az = 0, ig = 0, n = 0, exp_az;
        bit   az_ok = 1, ig_ok = 1;
        e.sign = comp_int;
        if (cross_at > 0) begin
            e.result = 12'(cross_at - 1);
            e.err    = 1'b0;
        end else begin
            e.result = 12'(MaxDeint);
            e.err    = 1'b1;
        end
        exp_q.push_back(e);

        bus.analog_ready_i = (ready_rise == 0);
        bus.comp_i         = comp_int;
        bus.start_i        = 1'b1;
        step();
        bus.start_i = 1'b0;
        check("enter_az", 32'(bus.state_o), 32'd1);

        while (bus.state_o === 3'd1 && az < 200) begin
            az++;
            if (bus.afe_reset_o !== 1'b1 || bus.afe_sel_o !== AFE_AZ) az_ok = 0;
            if (az == ready_rise) bus.analog_ready_i = 1'b1;
            bus.start_i = poke_start;
            step();
            bus.start_i = 1'b0;
        end
        exp_az = (ready_rise > int'(SettleCycles)) ? ready_rise : int'(SettleCycles);
        check("az_cycles", 32'(az), 32'(exp_az));
        check("az_outputs", 32'(az_ok), 32'd1);

        while (bus.state_o === 3'd2 && ig < 200) begin
            ig++;
            if (bus.afe_reset_o !== 1'b0 || bus.afe_sel_o !== AFE_INT) ig_ok = 0;
            step();
        end
        check("int_cycles", 32'(ig), 32'(IntCycles));
        check("int_outputs", 32'(ig_ok), 32'd1);
        check("deint_sel", 32'(bus.afe_sel_o), 32'(AFE_DEINT));

        while (bus.state_o === 3'd3 && n < 200) begin
            n++;
            if (n == cross_at) bus.comp_i = ~comp_int;
            step();
        end
        check("deint_cycles", 32'(n), (cross_at > 0) ? 32'(cross_at) : 32'(MaxDeint + 1));

        check("done_state", 32'(bus.state_o), 32'd4);
        check("done_valid", 32'(bus.result_valid_o), 32'd1);
        check("done_afe_reset", 32'(bus.afe_reset_o), 32'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("result", 32'(bus.result_o), 32'(e.result));
            check("result_sign", 32'(bus.result_sign_o), 32'(e.sign));
            check("ref_sign", 32'(bus.ref_sign_o), 32'(e.sign));
            check("range_error", 32'(bus.range_error_o), 32'(e.err));
            last_exp = e;
        end
    endtask

    task automatic ack_done();
        bus.result_ack_i = 1'b1;
        step();
        bus.result_ack_i = 1'b0;
        check("ack_idle", 32'(bus.state_o), 32'd0);
        check("ack_valid", 32'(bus.result_valid_o), 32'd0);
        check("ack_busy", 32'(bus.busy_o), 32'd0);
        check("ack_result_kept", 32'(bus.result_o), 32'(last_exp.result));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(bus.state_o), 32'd0);
        check({tag, "_sel"}, 32'(bus.afe_sel_o), 32'd0);
        check({tag, "_afe_reset"}, 32'(bus.afe_reset_o), 32'd1);
        check({tag, "_ref"}, 32'(bus.ref_sign_o), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_valid"}, 32'(bus.result_valid_o), 32'd0);
        check({tag, "_result"}, 32'(bus.result_o), 32'd0);
        check({tag, "_sign"}, 32'(bus.result_sign_o), 32'd0);
        check({tag, "_err"}, 32'(bus.range_error_o), 32'd0);
    endtask

    initial begin
        bus.start_i        = 1'b0;
        bus.abort_i        = 1'b0;
        bus.comp_i         = 1'b0;
        bus.analog_ready_i = 1'b0;
        bus.result_ack_i   = 1'b0;
        last_exp           = '0;

        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Ack outside DONE does nothing.
        bus.result_ack_i = 1'b1;
        step();
        bus.result_ack_i = 1'b0;
        check("stray_ack", 32'(bus.state_o), 32'd0);

        // Nominal: crossing on 6th DEINT cycle, result held until ack.
        run_conv(1'b1, 6, 0, 1'b0);
        repeat (3) step();
        check("hold_valid", 32'(bus.result_valid_o), 32'd1);
        check("hold_result", 32'(bus.result_o), 32'd5);
        ack_done();

        run_conv(1'b0, 0, 0, 1'b0);   // overrange
        ack_done();
        run_conv(1'b1, 3, 10, 1'b1);  // ready stall with ignored starts
        ack_done();
        run_conv(1'b0, 1, 0, 1'b0);   // crossing on first DEINT cycle
        ack_done();
        run_conv(1'b1, 21, 0, 1'b0);  // crossing on the limit cycle
        ack_done();

        // Abort in the 3rd INTEGRATE cycle.
        bus.comp_i  = 1'b0;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        wait_state(3'd2, "abort_reach_int");
        repeat (2) step();
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        check("abort_state", 32'(bus.state_o), 32'd0);
        check("abort_sel", 32'(bus.afe_sel_o), 32'd0);
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_valid", 32'(bus.result_valid_o), 32'd0);
        check("abort_result", 32'(bus.result_o), 32'(last_exp.result));
        check("abort_sign", 32'(bus.result_sign_o), 32'(last_exp.sign));
        check("abort_err", 32'(bus.range_error_o), 32'(last_exp.err));

        // Start together with ack in DONE: ack wins, no new conversion.
        run_conv(1'b1, 4, 0, 1'b0);
        bus.start_i      = 1'b1;
        bus.result_ack_i = 1'b1;
        step();
        bus.start_i      = 1'b0;
        bus.result_ack_i = 1'b0;
        check("start_ack_state", 32'(bus.state_o), 32'd0);
        check("start_ack_valid", 32'(bus.result_valid_o), 32'd0);
        repeat (2) step();
        check("start_ack_no_conv", 32'(bus.busy_o), 32'd0);

        // Asynchronous reset in DEINT, then start on the first edge after release.
        bus.comp_i  = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        wait_state(3'd3, "rst_reach_deint");
        step();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n       = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        check("post_rst_start", 32'(bus.state_o), 32'd1);
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        check("post_rst_abort", 32'(bus.state_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
